// File: rtl/bios_shadow_copy.sv
// Boot-time shadow copy engine: walks the BIOS ROM one word at a time, writes each
// word to RAM over a ready handshake and keeps a 16-bit checksum of the words accepted.
module bios_shadow_copy #(
    parameter int          WORDS     = 4096,
    parameter logic [17:0] SRC_BASE  = 18'h00000,
    parameter logic [17:0] DST_BASE  = 18'h00000,
    parameter int          READ_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [17:0] bios_addr,
    output logic [1:0]  bios_be,
    output logic        bios_ce,
    input  logic [15:0] bios_data,
    output logic [17:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic        ram_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    // The index is 17 bits wide so that WORDS = 65536 can still reach its last word.
    localparam logic [16:0] LAST  = 17'(WORDS - 1);
    localparam logic [3:0]  WLAST = 4'(READ_WAIT - 1);

    state_t      state, nxt_state;
    logic [16:0] index, nxt_index;
    logic [3:0]  wcnt, nxt_wcnt;
    logic [17:0] nxt_bios_addr, nxt_ram_addr;
    logic [1:0]  nxt_bios_be;
    logic        nxt_bios_ce, nxt_ram_we, nxt_busy, nxt_done;
    logic [15:0] nxt_ram_wdata, nxt_checksum;
    logic [17:0] idx18;

    assign idx18 = {1'b0, index};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            index     <= '0;
            wcnt      <= '0;
            bios_addr <= '0;
            bios_be   <= '0;
            bios_ce   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
        end else begin
            state     <= nxt_state;
            index     <= nxt_index;
            wcnt      <= nxt_wcnt;
            bios_addr <= nxt_bios_addr;
            bios_be   <= nxt_bios_be;
            bios_ce   <= nxt_bios_ce;
            ram_addr  <= nxt_ram_addr;
            ram_wdata <= nxt_ram_wdata;
            ram_we    <= nxt_ram_we;
            busy      <= nxt_busy;
            done      <= nxt_done;
            checksum  <= nxt_checksum;
        end
    end

    always_comb begin
        nxt_state     = state;
        nxt_index     = index;
        nxt_wcnt      = wcnt;
        nxt_bios_addr = bios_addr;
        nxt_bios_be   = bios_be;
        nxt_bios_ce   = bios_ce;
        nxt_ram_addr  = ram_addr;
        nxt_ram_wdata = ram_wdata;
        nxt_ram_we    = ram_we;
        nxt_busy      = busy;
        nxt_done      = done;
        nxt_checksum  = checksum;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    nxt_state     = READ;
                    nxt_index     = '0;
                    nxt_wcnt      = '0;
                    nxt_checksum  = '0;
                    nxt_busy      = 1'b1;
                    nxt_done      = 1'b0;
                    nxt_bios_ce   = 1'b1;
                    nxt_bios_be   = 2'b11;
                    nxt_bios_addr = SRC_BASE;
                end
            end
            READ: begin
                if (wcnt == WLAST) begin
                    nxt_state     = WRITE;
                    nxt_ram_wdata = bios_data;
                    nxt_ram_addr  = DST_BASE + idx18;
                    nxt_ram_we    = 1'b1;
                    nxt_bios_ce   = 1'b0;
                    nxt_bios_be   = 2'b00;
                end else begin
                    nxt_wcnt = wcnt + 4'd1;
                end
            end
            WRITE: begin
                // Address and data stay registered while ram_ready is low, so a stall is free.
                if (ram_ready) begin
                    nxt_checksum = checksum + ram_wdata;
                    nxt_ram_we   = 1'b0;
                    if (index == LAST) begin
                        nxt_state = DONE;
                        nxt_busy  = 1'b0;
                        nxt_done  = 1'b1;
                    end else begin
                        nxt_state     = READ;
                        nxt_index     = index + 17'd1;
                        nxt_wcnt      = '0;
                        nxt_bios_ce   = 1'b1;
                        nxt_bios_be   = 2'b11;
                        nxt_bios_addr = SRC_BASE + idx18 + 18'd1;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bios_shadow_copy.sv
// Directed bench: dut0 covers basic copy, stall, abort and start handling;
// dut1 covers source address wrap with a longer ROM wait.
module tb_bios_shadow_copy;
    logic clk, rst_n;
    logic start0, ready0, start1, ready1;
    logic [17:0] bios_addr0, ram_addr0, bios_addr1, ram_addr1;
    logic [1:0]  bios_be0, bios_be1;
    logic        bios_ce0, ram_we0, busy0, done0, bios_ce1, ram_we1, busy1, done1;
    logic [15:0] bios_data0, ram_wdata0, checksum0, bios_data1, ram_wdata1, checksum1;

    int tests = 0, fails = 0, be_err = 0, excl_err = 0;
    logic [33:0] q0[$], q1[$];
    logic [17:0] aq1[$];
    logic [15:0] img [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    bios_shadow_copy #(.WORDS(4), .SRC_BASE(18'h00000), .DST_BASE(18'h01000), .READ_WAIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bios_addr(bios_addr0), .bios_be(bios_be0),
        .bios_ce(bios_ce0), .bios_data(bios_data0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
        .ram_we(ram_we0), .ram_ready(ready0), .busy(busy0), .done(done0), .checksum(checksum0));

    bios_shadow_copy #(.WORDS(4), .SRC_BASE(18'h3FFFE), .DST_BASE(18'h00000), .READ_WAIT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bios_addr(bios_addr1), .bios_be(bios_be1),
        .bios_ce(bios_ce1), .bios_data(bios_data1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
        .ram_we(ram_we1), .ram_ready(ready1), .busy(busy1), .done(done1), .checksum(checksum1));

    // ROM images: dut0 sees 1111,2222,3333,4444 at 0..3; dut1 sees addr[15:0]+0100.
    assign bios_data0 = 16'h1111 * {14'd0, bios_addr0[1:0]} + 16'h1111;
    assign bios_data1 = bios_addr1[15:0] + 16'h0100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            if (ram_we0 && ready0) q0.push_back({ram_addr0, ram_wdata0});
            if (ram_we1 && ready1) q1.push_back({ram_addr1, ram_wdata1});
            if (bios_ce1) aq1.push_back(bios_addr1);
        end
        if ((bios_ce0 && ram_we0) || (bios_ce1 && ram_we1)) excl_err++;
        if ((bios_ce0 ? bios_be0 != 2'b11 : bios_be0 != 2'b00) ||
            (bios_ce1 ? bios_be1 != 2'b11 : bios_be1 != 2'b00)) be_err++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] outs0();
        return {bios_addr0, bios_be0, bios_ce0, ram_addr0, ram_wdata0, ram_we0, busy0, done0, checksum0};
    endfunction

    function automatic logic [127:0] outs1();
        return {bios_addr1, bios_be1, bios_ce1, ram_addr1, ram_wdata1, ram_we1, busy1, done1, checksum1};
    endfunction

    // Leaves the caller on the falling edge right after the start-sampling edge.
    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int bound, output int cyc);
        cyc = 0;
        while (!(sel ? done1 : done0) && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_log0(input string tag);
        check({tag, " count"}, 128'(q0.size()), 128'd4);
        for (int i = 0; i < q0.size() && i < 4; i++)
            check(tag, 128'(q0[i]), 128'({18'h01000 + 18'(i), img[i]}));
    endtask

    initial begin
        int cyc, bcnt;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;

        // Reset values, start toggling under reset
        repeat (2) begin
            @(negedge clk); start0 = 1'b1; start1 = 1'b1;
            @(negedge clk); start0 = 1'b0; start1 = 1'b0;
        end
        check("reset outs0", outs0(), 128'd0);
        check("reset outs1", outs1(), 128'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post-reset idle outs0", outs0(), 128'd0);

        // Basic copy: 8 cycles, busy throughout
        q0.delete();
        pulse_start(0);
        bcnt = 0; cyc = 0;
        while (!done0 && cyc < 50) begin
            if (busy0) bcnt++;
            @(negedge clk);
            cyc++;
        end
        check("basic done latency", 128'(cyc), 128'd8);
        check("basic busy cycles", 128'(bcnt), 128'd8);
        check("basic busy low at done", 128'(busy0), 128'd0);
        check("basic checksum", 128'(checksum0), 128'hAAAA);
        check_log0("basic ram write");
        repeat (2) @(negedge clk);
        check("done sticky", 128'(done0), 128'd1);
        check("done holds ram_addr/wdata", 128'({ram_addr0, ram_wdata0, ram_we0, bios_ce0}),
              128'({18'h01003, 16'h4444, 1'b0, 1'b0}));

        // Stall on word 1 for 3 cycles
        q0.delete();
        pulse_start(0);
        repeat (3) @(negedge clk);
        check("stall word1 in write", 128'({ram_we0, ram_addr0, ram_wdata0}), 128'({1'b1, 18'h01001, 16'h2222}));
        ready0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall held", 128'({ram_we0, ram_addr0, ram_wdata0, bios_ce0}),
                  128'({1'b1, 18'h01001, 16'h2222, 1'b0}));
        end
        ready0 = 1'b1;
        wait_done(0, 50, cyc);
        check("stall done latency", 128'(cyc + 6), 128'd11);
        check("stall checksum", 128'(checksum0), 128'hAAAA);
        check_log0("stall ram write");

        // Abort after two words accepted
        q0.delete();
        pulse_start(0);
        repeat (4) @(negedge clk);
        check("abort pre-state", 128'({bios_ce0, bios_addr0, checksum0}), 128'({1'b1, 18'h00002, 16'h3333}));
        check("abort words accepted", 128'(q0.size()), 128'd2);
        #2 rst_n = 1'b0;
        #1 check("abort async clear", outs0(), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q0.delete();
        pulse_start(0);
        check("restart first addr", 128'({bios_ce0, bios_addr0}), 128'({1'b1, 18'h00000}));
        wait_done(0, 50, cyc);
        check("abort recopy latency", 128'(cyc), 128'd8);
        check("abort recopy checksum", 128'(checksum0), 128'hAAAA);
        check_log0("abort recopy");

        // Start in READ and WRITE is ignored
        q0.delete();
        pulse_start(0);
        start0 = 1'b1;
        @(negedge clk);
        check("start ignored in write", 128'({ram_we0, ram_addr0}), 128'({1'b1, 18'h01000}));
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 50, cyc);
        check("ignored start latency", 128'(cyc + 2), 128'd8);
        check("ignored start checksum", 128'(checksum0), 128'hAAAA);
        check_log0("ignored start");

        // Restart from DONE
        q0.delete();
        pulse_start(0);
        check("restart clears", 128'({done0, busy0, checksum0}), 128'({1'b0, 1'b1, 16'h0000}));
        wait_done(0, 50, cyc);
        check("restart latency", 128'(cyc), 128'd8);
        check("restart checksum", 128'(checksum0), 128'hAAAA);
        check_log0("restart");

        // Source wrap with READ_WAIT = 3
        pulse_start(1);
        wait_done(1, 100, cyc);
        check("wrap done latency", 128'(cyc), 128'd16);
        check("wrap checksum", 128'(checksum1), 128'h03FE);
        check("wrap ce cycles", 128'(aq1.size()), 128'd12);
        if (aq1.size() == 12) begin
            check("wrap addr 0", 128'({aq1[0], aq1[1], aq1[2]}), 128'({18'h3FFFE, 18'h3FFFE, 18'h3FFFE}));
            check("wrap addr 1", 128'({aq1[3], aq1[4], aq1[5]}), 128'({18'h3FFFF, 18'h3FFFF, 18'h3FFFF}));
            check("wrap addr 2", 128'({aq1[6], aq1[7], aq1[8]}), 128'({18'h00000, 18'h00000, 18'h00000}));
            check("wrap addr 3", 128'({aq1[9], aq1[10], aq1[11]}), 128'({18'h00001, 18'h00001, 18'h00001}));
        end
        check("wrap ram writes", 128'(q1.size()), 128'd4);
        if (q1.size() == 4)
            check("wrap first write", 128'(q1[0]), 128'({18'h00000, 16'h00FE}));

        check("bios_be encoding", 128'(be_err), 128'd0);
        check("ce/we exclusive", 128'(excl_err), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bios_shadow_copy.md
Name: bios_shadow_copy

Overview:
Boot-time copy engine that sits directly downstream of the BIOS ROM and consumes its read data. After a start pulse it walks the ROM word by word. Each word goes out on a simple RAM write handshake, so the CPU can later execute from fast RAM. It reports busy, done and a 16-bit checksum of the copied image, so boot firmware can validate the shadow.

Parameters:
WORDS, 4096, number of 16-bit words to copy; legal range 1..65536
SRC_BASE, 18'h00000, first ROM word address
DST_BASE, 18'h00000, first RAM word address
READ_WAIT, 1, cycles bios_ce/bios_addr are held before bios_data is captured; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin copy; sampled only in IDLE or DONE
bios_addr  output  18  ROM word address
bios_be  output  2  ROM byte enable; constant 2'b11 while bios_ce=1, else 2'b00
bios_ce  output  1  ROM chip enable
bios_data  input  16  ROM read data (combinational from bios_addr)
ram_addr  output  18  RAM word address
ram_wdata  output  16  RAM write data
ram_we  output  1  RAM write request
ram_ready  input  1  RAM accepts the write on a rising edge where ram_we=1 and ram_ready=1
busy  output  1  copy in progress
done  output  1  copy complete; sticky until next start or reset
checksum  output  16  running sum mod 2^16 of accepted words

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low (rst_n). All state is registered on the rising edge of clk.
- Reset: state=IDLE, index=0, and every output is 0: bios_addr, bios_be, bios_ce, ram_addr, ram_wdata, ram_we, busy, done, checksum.
- An rst_n assertion mid-copy aborts immediately and returns everything to the reset values. The RAM may hold a partial image. No resume is possible; the next start copies from index 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE: start=1 at an edge -> READ. On the same edge: index=0, checksum=0, busy=1, done=0.
- READ:
  - bios_ce=1, bios_be=2'b11, bios_addr=(SRC_BASE+index) mod 2^18.
  - Internal wait counter runs READ_WAIT cycles.
  - On the edge ending the last wait cycle: ram_wdata<=bios_data, then -> WRITE.
- WRITE:
  - bios_ce=0, bios_be=2'b00.
  - ram_we=1, ram_addr=(DST_BASE+index) mod 2^18.
  - ram_wdata and ram_addr are held stable until acceptance.
  - On the edge with ram_ready=1: checksum+=ram_wdata (mod 2^16).
    - If index==WORDS-1 -> DONE; ram_we=0, busy=0, done=1.
    - Otherwise index+=1 -> READ.
  - ram_ready=0 stalls indefinitely. No ROM access is issued during a stall.
- DONE:
  - done=1, busy=0, all enables 0.
  - checksum holds its final value.
  - ram_addr and ram_wdata hold their last values.
  - start=1 -> same transition as from IDLE (restart).
- start is ignored in READ and WRITE.
- Address wrap: source and destination addresses each wrap mod 2^18, independently. There is no error flag.
- Index counter is 17 bits wide so that WORDS=65536 terminates correctly.
- Latency, with READ_WAIT=R and ram_ready tied to 1:
  - Each word takes R+1 cycles.
  - done rises WORDS*(R+1) cycles after the start-sampling edge.
- bios_ce and ram_we are never asserted in the same cycle.

Test Plan:
1. Reset values: hold rst_n=0 and toggle start -> all outputs 0, state IDLE. Release rst_n -> outputs remain 0 until start.
2. Basic copy: WORDS=4, SRC_BASE=0, DST_BASE=18'h01000, R=1, ROM=1111,2222,3333,4444, ram_ready=1.
   - RAM writes: 01000<-1111, 01001<-2222, 01002<-3333, 01003<-4444.
   - checksum=AAAA.
   - done=1 exactly 8 cycles after the start edge.
   - busy high for those 8 cycles.
3. Stall: hold ram_ready=0 for 3 cycles on word 1.
   - ram_we, ram_addr=01001 and ram_wdata=2222 held for the full stall.
   - bios_ce stays 0 during the stall.
   - done arrives 3 cycles late; checksum still AAAA.
4. Abort: drop rst_n after 2 words are accepted.
   - All outputs go to 0 asynchronously (without waiting for a clock edge).
   - A new start recopies from ROM address 0; final checksum AAAA.
5. Start handling:
   - Pulse start while in READ and while in WRITE -> no effect; copy sequence unchanged.
   - Pulse start in DONE -> done=0, checksum=0, copy repeats identically.
6. Wrap and timing: SRC_BASE=18'h3FFFE, WORDS=4, R=3.
   - bios_addr sequence 3FFFE, 3FFFF, 00000, 00001.
   - Each address held 3 cycles with bios_be=11.
   - done at cycle 16.
   - checksum equals the mod-2^16 sum of those four ROM words.
